// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit master.
// Holds funct3 encodings, the FSM state type and the latched operation record.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_ADDR_W  = 32;
    localparam int LSU_WADDR_W = LSU_ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsu_state_e;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lo;
    } lsu_op_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, load extraction
// with sign/zero extension, and detection of illegal or misaligned operations.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_illegal
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wstrb   = 4'b0000;
        o_wdata   = 32'h0;
        o_ldata   = 32'h0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_ldata = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_wstrb   = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata   = {2{i_wdata[15:0]}};
                o_ldata   = {{16{w_half[15]}}, w_half};
                o_illegal = i_addr_lo[0];
            end
            F3_W: begin
                o_wstrb   = 4'b1111;
                o_wdata   = i_wdata;
                o_ldata   = i_rdata;
                o_illegal = |i_addr_lo;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                o_ldata   = {24'h0, w_byte};
                o_illegal = i_store;
            end
            F3_HU: begin
                o_ldata   = {16'h0, w_half};
                o_illegal = i_store | i_addr_lo[0];
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/lsu_master.sv
// Data-memory initiator: accepts one core load/store, issues a whole-word
// strobed request, waits for read data and returns an extended result.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = LSU_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_store,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [3:0]        o_mem_wstrb,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e        r_state;
    lsu_op_t           r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_valid, r_mem_we;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;
    logic              r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic [31:0]       r_rsp_data;

    logic              w_idle, w_expired, w_illegal;
    logic [2:0]        w_f3;
    logic [1:0]        w_lo;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata, w_ldata;

    assign w_idle    = (r_state == IDLE);
    assign w_expired = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT));

    // In IDLE the lane logic looks at the incoming request; afterwards at the latched op.
    assign w_f3 = w_idle ? i_req_funct3    : r_op.funct3;
    assign w_lo = w_idle ? i_req_addr[1:0] : r_op.lo;

    lsu_align u_align (
        .i_store   (w_idle ? i_req_store : r_mem_we),
        .i_funct3  (w_f3),
        .i_addr_lo (w_lo),
        .i_wdata   (i_req_wdata),
        .i_rdata   (i_mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_op          <= '0;
            r_cnt         <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wstrb   <= 4'b0000;
            r_mem_wdata   <= 32'h0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 32'h0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_op          <= '{funct3: i_req_funct3, lo: i_req_addr[1:0]};
                    r_rsp_data    <= 32'h0;
                    r_rsp_err     <= 1'b0;
                    r_rsp_timeout <= 1'b0;
                    if (w_illegal) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_state     <= REQ;
                        r_cnt       <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= i_req_store;
                        r_mem_addr  <= i_req_addr[ADDR_W-1:2];
                        r_mem_wstrb <= i_req_store ? w_wstrb : 4'b0000;
                        r_mem_wdata <= i_req_store ? w_wdata : 32'h0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A handshake in the expiry cycle takes priority over the abort.
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_mem_we) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT_R;
                        end
                    end else if (w_expired) begin
                        r_mem_valid   <= 1'b0;
                        r_state       <= RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                WAIT_R: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (i_mem_rvalid) begin
                        r_rsp_data  <= w_ldata;
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else if (w_expired) begin
                        r_state       <= RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = w_idle;
    assign o_mem_valid   = r_mem_valid;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wstrb   = r_mem_wstrb;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Initiator side of the data-memory interface. Accepts one decoded RV32I load/store from the core's memory stage and checks alignment.
- Drives a word-addressed memory request with byte strobes over a valid/ready handshake, then waits for read data.
- Returns lane-extracted, sign- or zero-extended load data and an error flag to the core.
- Replaces the core's direct lane selection, so the memory responder only ever sees whole-word accesses with strobes.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.
- TIMEOUT, 255, maximum cycles spent in REQ or WAIT_R before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core presents an operation
- req_ready  out  1  block can accept; equals 1 only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- mem_valid  out  1  request valid
- mem_ready  in  1  responder accepts the request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2]
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  32  lane-replicated write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- rsp_valid  out  1  result available
- rsp_ready  in  1  core consumes the result
- rsp_data  out  32  extended load data; 0 for stores and on error
- rsp_err  out  1  misaligned, illegal or timed-out operation
- rsp_timeout  out  1  error cause was a timeout

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; all registered outputs clear to 0 (mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_valid, rsp_data, rsp_err, rsp_timeout).
  - The timeout counter clears to 0.
  - req_ready reads 1 from the first cycle after reset.
- Reset mid-operation abandons the transaction. mem_valid and rsp_valid are 0 the next cycle, and a later mem_rvalid is ignored.
- States:
  - IDLE: a handshake (req_valid & req_ready) latches the operation.
    - If illegal, go to RESP with rsp_err=1 and no memory traffic.
    - Otherwise go to REQ.
  - REQ: mem_valid=1; addr, we, wstrb and wdata are held stable until mem_ready.
    - Store handshake goes to RESP.
    - Load handshake goes to WAIT_R.
  - WAIT_R: mem_rvalid=1 captures the extracted data and goes to RESP. mem_rvalid is ignored in every other state.
  - RESP: rsp_valid=1 and all rsp_* stay stable until rsp_ready, then return to IDLE.
- Latency with a zero-wait responder (mem_ready=1, mem_rvalid the cycle after the handshake):
  - load: rsp_valid 3 cycles after request acceptance.
  - store: rsp_valid 2 cycles after request acceptance.
- Illegal operations:
  - funct3 011/110/111 is illegal.
  - Stores with funct3 1xx are illegal.
  - Halfword access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
- Store lane generation:
  - sb: wstrb = 0001<<addr[1:0]; wdata = byte replicated x4.
  - sh: wstrb = 0011<<{addr[1],1'b0}; wdata = half replicated x2.
  - sw: wstrb = 1111.
- Loads drive mem_wstrb=0000 and mem_we=0.
- Load extraction: select the byte at addr[1:0] or the half at addr[1]. lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_R and clears on entry to REQ.
  - If TIMEOUT>0 and the counter reaches TIMEOUT, go to RESP with rsp_err=1, rsp_timeout=1, and drop mem_valid.
  - Counter width is $clog2(TIMEOUT+1).
  - A handshake in the same cycle as expiry wins over the timeout.
- Simultaneous events: in RESP, rsp_ready=1 with req_valid=1 does not accept the new request that cycle; req_ready rises the next cycle.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/REQ/WAIT_R/RESP.
  - Width constant for the word address.
- Sub-module lsu_align, purely combinational:
  - store side: wstrb/wdata from funct3, addr[1:0] and wdata.
  - load side: extracted, extended data from funct3, addr[1:0] and rdata.
  - illegal-op flag.
- lsu_master holds the FSM, request/response registers and the timeout counter.

Test Plan:
- sb addr=0x103, wdata=0x000000AB, mem_ready=1 -> mem_addr=0x40, wstrb=1000, wdata=0xABABABAB, we=1; rsp_data=0, rsp_err=0 two cycles after acceptance.
- lh addr=0x202, rdata=0x8001_1234 -> rsp_data=0xFFFF8001; lhu same -> 0x00008001; lb addr=0x201 -> 0x00000012.
- lw addr=0x6 -> no mem_valid ever; rsp_err=1, rsp_timeout=0, rsp_data=0 the cycle after acceptance.
- mem_ready held 0 for 3 cycles on sw addr=0x10 -> mem_addr/wstrb/wdata stable throughout; one write handshake; rsp_ready held 0 for 2 cycles -> rsp_valid held, req_ready=0.
- TIMEOUT=4, load with mem_rvalid never asserted -> rsp_err=1, rsp_timeout=1 after 4 cycles in WAIT_R; a late mem_rvalid is ignored.
- rst_n low during WAIT_R -> next cycle all outputs 0 and req_ready=1; a following lbu completes normally.
